// File: rtl/ibram_arbiter_if.sv
// Bus bundle between fetch / UART loader, the ibram_arbiter and the instruction BRAM port.
// The slave modport is the arbiter's view; master is the view of the surrounding logic.
interface ibram_arbiter_if;
   logic        fetch_new_request;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic        fetch_data_valid;
   logic [31:0] fetch_data_out;

   logic        loader_req;
   logic        loader_we;
   logic [31:0] loader_addr;
   logic [3:0]  loader_be;
   logic [31:0] loader_wdata;
   logic        loader_hold;
   logic        loader_gnt;
   logic        loader_rvalid;
   logic [31:0] loader_rdata;

   logic [29:0] bram_addr;
   logic        bram_en;
   logic [3:0]  bram_be;
   logic [31:0] bram_data_in;
   logic [31:0] bram_data_out;

   modport slave (
      input  fetch_new_request, fetch_addr,
      output fetch_ready, fetch_data_valid, fetch_data_out,
      input  loader_req, loader_we, loader_addr, loader_be, loader_wdata, loader_hold,
      output loader_gnt, loader_rvalid, loader_rdata,
      output bram_addr, bram_en, bram_be, bram_data_in,
      input  bram_data_out
   );

   modport master (
      output fetch_new_request, fetch_addr,
      input  fetch_ready, fetch_data_valid, fetch_data_out,
      output loader_req, loader_we, loader_addr, loader_be, loader_wdata, loader_hold,
      input  loader_gnt, loader_rvalid, loader_rdata,
      input  bram_addr, bram_en, bram_be, bram_data_in,
      output bram_data_out
   );
endinterface

// File: rtl/ibram_arbiter.sv
// ibram_arbiter: shares the instruction BRAM port between fetch (priority) and the UART loader.
// Define IBRAM_ARB_STARVE_EN to add the loader starvation counter and forced loader slot.
module ibram_arbiter #(
   parameter int unsigned MAX_FETCH_BURST = 8
) (
   input  logic           clk,
   input  logic           rst,
   ibram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_FETCH  = 2'd1,
      OWN_LOADER = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      ARB_FETCH_PRI = 2'd0,
      ARB_FORCED    = 2'd1,
      ARB_HOLD      = 2'd2
   } arb_e;

   localparam logic [7:0] MAX_C = 8'(MAX_FETCH_BURST);

   owner_e      rd_owner_q;
   owner_e      rd_owner_d;
   arb_e        arb_state_s;
   logic        force_ldr_s;
   logic        fetch_ready_s;
   logic        fetch_gnt_s;
   logic        loader_gnt_s;
   logic        bram_en_s;
   logic [29:0] bram_addr_s;
   logic [3:0]  bram_be_s;
   logic [31:0] bram_data_in_s;
   logic        unused_s;

`ifdef IBRAM_ARB_STARVE_EN
   logic [7:0] starve_cnt_q;
   logic [7:0] starve_cnt_d;

   assign force_ldr_s = bus.loader_req & (starve_cnt_q == MAX_C);
   assign unused_s    = ^{bus.fetch_addr[1:0], bus.loader_addr[1:0]};

   // Counts fetch grants taken while the loader is waiting; saturates at the burst limit.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!bus.loader_req || loader_gnt_s) begin
         starve_cnt_d = 8'd0;
      end else if (fetch_gnt_s && (starve_cnt_q < MAX_C)) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= 8'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign force_ldr_s = 1'b0;
   assign unused_s    = ^{bus.fetch_addr[1:0], bus.loader_addr[1:0], MAX_C};
`endif

   // Arbitration mode: hold beats a forced slot, otherwise fetch has priority.
   always_comb begin
      arb_state_s = ARB_FETCH_PRI;
      if (bus.loader_hold) begin
         arb_state_s = ARB_HOLD;
      end else if (force_ldr_s) begin
         arb_state_s = ARB_FORCED;
      end else begin
         arb_state_s = ARB_FETCH_PRI;
      end
   end

   // Grant decode; fetch_ready never looks at the fetch request so no loop forms upstream.
   always_comb begin
      fetch_ready_s = 1'b0;
      fetch_gnt_s   = 1'b0;
      loader_gnt_s  = 1'b0;
      if (rst) begin
         fetch_ready_s = 1'b0;
      end else begin
         case (arb_state_s)
            ARB_FETCH_PRI: begin
               fetch_ready_s = 1'b1;
               fetch_gnt_s   = bus.fetch_new_request;
               loader_gnt_s  = bus.loader_req & ~bus.fetch_new_request;
            end
            ARB_FORCED, ARB_HOLD: begin
               loader_gnt_s = bus.loader_req;
            end
            default: begin
               fetch_ready_s = 1'b0;
            end
         endcase
      end
   end

   // BRAM port mux and next read owner; loader writes return nothing.
   always_comb begin
      bram_en_s      = 1'b0;
      bram_addr_s    = 30'd0;
      bram_be_s      = 4'd0;
      bram_data_in_s = 32'd0;
      rd_owner_d     = OWN_NONE;
      if (fetch_gnt_s) begin
         bram_en_s   = 1'b1;
         bram_addr_s = bus.fetch_addr[31:2];
         rd_owner_d  = OWN_FETCH;
      end else if (loader_gnt_s) begin
         bram_en_s      = 1'b1;
         bram_addr_s    = bus.loader_addr[31:2];
         bram_be_s      = bus.loader_we ? bus.loader_be : 4'd0;
         bram_data_in_s = bus.loader_wdata;
         rd_owner_d     = bus.loader_we ? OWN_NONE : OWN_LOADER;
      end else begin
         rd_owner_d = OWN_NONE;
      end
   end

   // Tracks who owns the data coming back from the 1-cycle BRAM read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_owner_q <= OWN_NONE;
      end else begin
         rd_owner_q <= rd_owner_d;
      end
   end

   assign bus.fetch_ready      = fetch_ready_s;
   assign bus.loader_gnt       = loader_gnt_s;
   assign bus.bram_en          = bram_en_s;
   assign bus.bram_addr        = bram_addr_s;
   assign bus.bram_be          = bram_be_s;
   assign bus.bram_data_in     = bram_data_in_s;
   // Masking with rst drops a read granted just before reset.
   assign bus.fetch_data_valid = ~rst & (rd_owner_q == OWN_FETCH);
   assign bus.loader_rvalid    = ~rst & (rd_owner_q == OWN_LOADER);
   assign bus.fetch_data_out   = bus.bram_data_out;
   assign bus.loader_rdata     = bus.bram_data_out;
endmodule

// File: tb/tb_ibram_arbiter.sv
// Self-checking bench for ibram_arbiter: per-cycle grant model plus a read-data scoreboard.
module tb_ibram_arbiter;
   localparam int MAX = 8;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   streak = 0;
   int   lg_cnt = 0;
   logic last_lgnt = 1'b0;
   exp_t fq[$];
   exp_t lq[$];
   logic [31:0] mem_ref [256];
   logic [31:0] mem_bram [256];
   logic [31:0] bram_dout_q = 32'd0;

   ibram_arbiter_if bus();

   ibram_arbiter #(.MAX_FETCH_BURST(MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.bram_data_out = bram_dout_q;

   function automatic logic [31:0] init_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      if (i == 64) return 32'hDEAD_BEEF;
      return {b, ~b, b ^ 8'h5A, 8'hC3};
   endfunction

   // BRAM model: 1-cycle read latency, byte writes; contents restored on reset.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         for (int i = 0; i < 256; i++) mem_bram[i] <= init_word(i);
      end else if (bus.bram_en) begin
         for (int b = 0; b < 4; b++)
            if (bus.bram_be[b]) mem_bram[bus.bram_addr[7:0]][8*b +: 8] <= bus.bram_data_in[8*b +: 8];
         bram_dout_q <= mem_bram[bus.bram_addr[7:0]];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Fetch is refused under reset, hold, or once the loader has waited MAX fetch grants.
   function automatic logic model_fetch_ready(input logic r, input logic lreq, input logic lh);
      logic forced;
`ifdef IBRAM_ARB_STARVE_EN
      forced = lreq && (streak >= MAX);
`else
      forced = 1'b0;
`endif
      return !r && !lh && !forced;
   endfunction

   task automatic drive(input logic r, input logic fnr, input logic [31:0] fa,
                        input logic lreq, input logic lwe, input logic [31:0] la,
                        input logic [3:0] lbe, input logic [31:0] lwd, input logic lh);
      logic e_fr, e_fg, e_lg, e_en;
      logic [29:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_din;
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      bus.fetch_new_request = fnr;
      bus.fetch_addr = fa;
      bus.loader_req = lreq;
      bus.loader_we = lwe;
      bus.loader_addr = la;
      bus.loader_be = lbe;
      bus.loader_wdata = lwd;
      bus.loader_hold = lh;
      if (r) begin
         fq.delete();
         lq.delete();
      end
      e_fr   = model_fetch_ready(r, lreq, lh);
      e_fg   = e_fr && fnr;
      e_lg   = !r && lreq && !e_fg;
      e_en   = e_fg || e_lg;
      e_addr = e_fg ? fa[31:2] : la[31:2];
      e_be   = (e_lg && lwe) ? lbe : 4'd0;
      e_din  = lwd;
      @(negedge clk);
      chk("fetch_ready", 32'(bus.fetch_ready), 32'(e_fr));
      chk("loader_gnt", 32'(bus.loader_gnt), 32'(e_lg));
      chk("bram_en", 32'(bus.bram_en), 32'(e_en));
      chk("bram_be", 32'(bus.bram_be), 32'(e_be));
      if (e_en) chk("bram_addr", 32'(bus.bram_addr), 32'(e_addr));
      if (e_lg) chk("bram_data_in", bus.bram_data_in, e_din);
      if (bus.loader_gnt) lg_cnt++;
      last_lgnt = e_lg;
      if (r) begin
         for (int i = 0; i < 256; i++) mem_ref[i] = init_word(i);
      end
      if (e_fg) begin
         e.due = cyc + 1;
         e.data = mem_ref[fa[9:2]];
         fq.push_back(e);
      end
      if (e_lg && !lwe) begin
         e.due = cyc + 1;
         e.data = mem_ref[la[9:2]];
         lq.push_back(e);
      end
      if (e_lg && lwe) begin
         for (int b = 0; b < 4; b++)
            if (lbe[b]) mem_ref[la[9:2]][8*b +: 8] = lwd[8*b +: 8];
      end
      if (r || !lreq || e_lg) streak = 0;
      else if (e_fg && streak < MAX) streak++;
   endtask

   task automatic idle(input logic r);
      drive(r, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0);
   endtask

   // Monitor: every returned word must match the oldest expectation, exactly one cycle after grant.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #4;
         if (bus.fetch_data_valid) begin
            if (fq.size() == 0) begin
               checks++; errors++;
               $display("FAIL fetch_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = fq.pop_front();
               chk("fetch_rdata", bus.fetch_data_out, e.data);
               chk("fetch_latency", 32'(cyc), 32'(e.due));
            end
         end else if (fq.size() != 0 && fq[0].due <= cyc) begin
            e = fq.pop_front();
            checks++; errors++;
            $display("FAIL fetch_valid: got 0 expected 1 (cycle %0d)", cyc);
         end
         if (bus.loader_rvalid) begin
            if (lq.size() == 0) begin
               checks++; errors++;
               $display("FAIL loader_rvalid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = lq.pop_front();
               chk("loader_rdata", bus.loader_rdata, e.data);
               chk("loader_latency", 32'(cyc), 32'(e.due));
            end
         end else if (lq.size() != 0 && lq[0].due <= cyc) begin
            e = lq.pop_front();
            checks++; errors++;
            $display("FAIL loader_rvalid: got 0 expected 1 (cycle %0d)", cyc);
         end
      end
   end

   initial begin
      logic        hold, r, fnr, fr_pred;
      logic        p_req, p_we;
      logic [31:0] p_addr, p_wd, fa;
      logic [3:0]  p_be;
      bus.fetch_new_request = 1'b0;
      bus.fetch_addr = 32'd0;
      bus.loader_req = 1'b0;
      bus.loader_we = 1'b0;
      bus.loader_addr = 32'd0;
      bus.loader_be = 4'd0;
      bus.loader_wdata = 32'd0;
      bus.loader_hold = 1'b0;

      for (int i = 0; i < 3; i++) idle(1'b1);
      idle(1'b0);
      drive(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0);
      idle(1'b0);

      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h200, 4'b0011, 32'h1234_5678, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h200, 4'd0, 32'd0, 1'b0);
      idle(1'b0);

      // Continuous contention: the loader only gets in through the forced slot.
      lg_cnt = 0;
      for (int i = 0; i < 12; i++)
         drive(1'b0, 1'b1, 32'(4 * i), 1'b1, 1'b0, 32'h300, 4'd0, 32'd0, 1'b0);
`ifdef IBRAM_ARB_STARVE_EN
      chk("contention_loader_grants", 32'(lg_cnt), 32'd1);
`else
      chk("contention_loader_grants", 32'(lg_cnt), 32'd0);
`endif
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h300, 4'd0, 32'd0, 1'b0);
      idle(1'b0);

      // Hold right after a fetch grant: the fetch still returns, then 16 loader writes.
      drive(1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0);
      lg_cnt = 0;
      for (int i = 0; i < 16; i++)
         drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'(32'h380 + 4 * i), 4'hF, $urandom, 1'b1);
      chk("hold_loader_grants", 32'(lg_cnt), 32'd16);
      drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h384, 4'd0, 32'd0, 1'b0);
      idle(1'b0);

      // Reset right after a loader read grant: that read never returns.
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h010, 4'd0, 32'd0, 1'b0);
      idle(1'b1);
      idle(1'b0);

      hold = 1'b0;
      p_req = 1'b0; p_we = 1'b0; p_addr = 32'd0; p_wd = 32'd0; p_be = 4'd0;
      for (int n = 0; n < 800; n++) begin
         r = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 19) == 0) hold = ~hold;
         if (!p_req && $urandom_range(0, 2) == 0) begin
            p_req  = 1'b1;
            p_we   = 1'($urandom_range(0, 1));
            p_addr = 32'($urandom_range(0, 1023));
            p_be   = 4'($urandom);
            p_wd   = $urandom;
         end
         fr_pred = model_fetch_ready(r, p_req, hold);
         fnr = fr_pred && ($urandom_range(0, 4) != 0);
         fa = 32'($urandom_range(0, 1023));
         drive(r, fnr, fa, p_req, p_we, p_addr, p_be, p_wd, hold);
         if (last_lgnt || r) p_req = 1'b0;
      end

      for (int i = 0; i < 3; i++) idle(1'b0);
      chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
      chk("loader_queue_drained", 32'(lq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
